ctrl_regs_mc: RTL and testbench
===============================

# ctrl_regs_mc

Parametrised multi-channel control/status register file for the MCDF datapath. It succeeds the fixed three-slave register set: channel count, avail width and bus widths are parameters, and it adds per-channel read-only status, error signalling and an optional write lock. A single initiator drives reads and writes over a cmd bus. The block drives enable, priority and packet-length controls to each slave channel and samples each channel's FIFO availability.

## Interface
- ADDR_WIDTH, 8, command address width; must be ≥ 8.
- DATA_WIDTH, 32, command data width; must be ≥ 8 and ≥ AVAIL_WIDTH.
- NUM_CH, 3, number of slave channels, 1..8.
- AVAIL_WIDTH, 8, width of each channel's avail count.
- clk  in  1  sole clock; all logic is on the rising edge.
- rstn  in  1  synchronous active-low reset.
- cmd  in  2  command: 00 idle, 01 write, 10 read, 11 reserved.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_data_w  in  DATA_WIDTH  write data.
- cmd_data_r  out  DATA_WIDTH  read data, registered.
- cmd_err  out  1  one-cycle error pulse.
- slv_avail  in  NUM_CH*AVAIL_WIDTH  per-channel FIFO free space; channel c occupies bits [c*AVAIL_WIDTH +: AVAIL_WIDTH].
- slv_en  out  NUM_CH  per-channel enable.
- slv_prio  out  2*NUM_CH  per-channel priority, [c*2 +: 2].
- slv_len  out  3*NUM_CH  per-channel packet length code, [c*3 +: 3].

## Operation
- Register map (low 2 address bits must be 00):
  - CTRL[c] at 0x00+4c, read/write. bit0 is en, bits2:1 are prio, bits5:3 are len, and upper bits read 0.
  - STAT[c] at 0x20+4c, read-only. Bits [AVAIL_WIDTH-1:0] hold avail_q[c]; upper bits read 0.
  - LOCK at 0x40; present only with the lock macro.
- avail_q[c] samples slv_avail every cycle, giving one register stage.
- Write (cmd=01) to a valid, unlocked CTRL[c]: the register updates at that edge, and the new slv_* value is visible the next cycle. Reserved data bits are ignored.
- Read (cmd=10): cmd_data_r is loaded at the edge with the addressed register's current value. cmd_data_r holds its value until the next read.
- An error is raised, with cmd_err=1 for exactly one cycle after the command, in these cases:
  - unmapped address, including a channel index ≥ NUM_CH;
  - misaligned address;
  - cmd=11;
  - write to STAT;
  - write to a locked CTRL.
- On an error the register state is unchanged. An erroneous read loads cmd_data_r with 0.
- Idle leaves all state unchanged, and cmd_err=0.

## Timing
- Reset values:
  - every CTRL[c] is en=1, prio=2'b11, len=3'b000;
  - avail_q is 0;
  - cmd_data_r is 0;
  - cmd_err is 0;
  - the lock is clear.
- Reset is sampled at the clock edge and overrides any command in that cycle. A write issued in the same cycle as rstn=0 is lost.
- Read latency is 1 cycle. A read issued at edge T returns avail_q as it stood before T, i.e. slv_avail from cycle T-2.
- Back-to-back commands are accepted every cycle, with no stall.
- A read of CTRL[c] in the cycle immediately after a write to it returns the new value.

## Configuration
- Macro: CTRL_REGS_LOCK_EN.
- Defined:
  - LOCK at 0x40 is implemented; bit0 is the lock state and reads back as the lock value.
  - Writing data[7:0]=0xA5 sets the lock. Writing any other value is ignored and raises no error.
  - While locked, CTRL writes are dropped and raise cmd_err.
  - The lock clears only on reset.
- Undefined:
  - address 0x40 is unmapped, so access to it raises cmd_err;
  - CTRL is always writable.

## Test plan
- Reset, then read every CTRL[c] -> each read returns 0x00000007 one cycle later, and slv_en is all ones.
- With NUM_CH=3, write 0x2A to CTRL[1] -> the next cycle shows slv_en[1]=0, slv_prio[3:2]=2'b01, slv_len[5:3]=3'b101, and other channels are unchanged. A subsequent read returns 0x2A.
- Drive slv_avail for ch2 to 0x3C, then read STAT[2] two cycles later -> cmd_data_r=0x3C. A write to STAT[2] -> cmd_err pulses and the next read still returns 0x3C.
- With NUM_CH=3, read 0x0C; separately read 0x02 and issue cmd=11 -> cmd_err=1 for one cycle each time, and cmd_data_r=0 after each read.
- With CTRL_REGS_LOCK_EN: write 0xA5 to 0x40, then 0x00 to CTRL[0] -> cmd_err pulses, slv_en[0] stays 1, and reading LOCK returns 1. Pulse rstn -> LOCK reads 0 and a CTRL[0] write succeeds.
- Assert rstn=0 during a write to CTRL[0] with data 0x00 -> the post-reset read returns 0x07.

Source files
------------

// File: rtl/ctrl_regs_mc_if.sv
// Command bus between the single initiator and the ctrl_regs_mc register file.
// The master drives cmd/address/write data; the slave returns registered read data and an error pulse.
interface ctrl_regs_mc_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data_w;
    logic [DATA_WIDTH-1:0] cmd_data_r;
    logic                  cmd_err;

    modport master (
        output cmd, cmd_addr, cmd_data_w,
        input  cmd_data_r, cmd_err
    );

    modport slave (
        input  cmd, cmd_addr, cmd_data_w,
        output cmd_data_r, cmd_err
    );
endinterface

// File: rtl/ctrl_regs_mc.sv
// Multi-channel control/status register file for the MCDF datapath (CTRL[c], STAT[c]).
// Define CTRL_REGS_LOCK_EN to add the write-once LOCK register at 0x40.
module ctrl_regs_mc #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 3,
    parameter int AVAIL_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    ctrl_regs_mc_if.slave                 bus,
    input  logic [NUM_CH*AVAIL_WIDTH-1:0] slv_avail,
    output logic [NUM_CH-1:0]             slv_en,
    output logic [2*NUM_CH-1:0]           slv_prio,
    output logic [3*NUM_CH-1:0]           slv_len
);
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam int         UW       = ADDR_WIDTH - 5;
    localparam logic [5:0] CTRL_RST = 6'b000_11_1;  // len=0, prio=3, en=1
    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    logic [5:0]             ctrl_q  [NUM_CH];
    logic [5:0]             ctrl_d  [NUM_CH];
    logic [AVAIL_WIDTH-1:0] avail_q [NUM_CH];
    logic [DATA_WIDTH-1:0]  data_r_q, data_r_d;
    logic                   err_q, err_d;
    logic                   locked;

    cmd_e            cmd;
    logic [UW-1:0]   region;
    logic [2:0]      idx;
    logic            aligned, ch_ok, ctrl_sel, stat_sel, lock_sel, mapped;
    logic [DATA_WIDTH-1:0] rd_data;
    logic            unused_data_bits;

    assign cmd     = cmd_e'(bus.cmd);
    assign region  = bus.cmd_addr[ADDR_WIDTH-1:5];
    assign idx     = bus.cmd_addr[4:2];
    assign aligned = (bus.cmd_addr[1:0] == 2'b00);
    assign ch_ok   = ({1'b0, idx} < NUM_CH_W);

    // 0x00-0x1F holds CTRL, 0x20-0x3F holds STAT; slots beyond NUM_CH are unmapped.
    assign ctrl_sel = aligned && (region == '0)       && ch_ok;
    assign stat_sel = aligned && (region == UW'(1))   && ch_ok;
    assign mapped   = ctrl_sel || stat_sel || lock_sel;

    // Reserved write-data bits are deliberately ignored.
    assign unused_data_bits = ^bus.cmd_data_w[DATA_WIDTH-1:6];

`ifdef CTRL_REGS_LOCK_EN
    logic lock_q, lock_d;

    assign lock_sel = aligned && (region == UW'(2)) && (idx == 3'd0);
    assign locked   = lock_q;
`else
    assign lock_sel = 1'b0;
    assign locked   = 1'b0;
`endif

    // Addressed register value, zero-extended; used only when a read hits the map.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_sel && idx == 3'(c)) rd_data[5:0]             = ctrl_q[c];
            if (stat_sel && idx == 3'(c)) rd_data[AVAIL_WIDTH-1:0] = avail_q[c];
        end
`ifdef CTRL_REGS_LOCK_EN
        if (lock_sel) rd_data[0] = lock_q;
`endif
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        data_r_d = data_r_q;
        err_d    = 1'b0;
`ifdef CTRL_REGS_LOCK_EN
        lock_d   = lock_q;
`endif
        case (cmd)
            CMD_WRITE: begin
                if (ctrl_sel && !locked) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (idx == 3'(c)) ctrl_d[c] = bus.cmd_data_w[5:0];
                    end
                end else if (lock_sel) begin
`ifdef CTRL_REGS_LOCK_EN
                    if (bus.cmd_data_w[7:0] == 8'hA5) lock_d = 1'b1;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            CMD_READ: begin
                if (mapped) begin
                    data_r_d = rd_data;
                end else begin
                    data_r_d = '0;
                    err_d    = 1'b1;
                end
            end
            CMD_RSVD: err_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the register arrays are tiny flop banks with defined reset values, so they are reset like any other state.
            for (int c = 0; c < NUM_CH; c++) begin
                ctrl_q[c]  <= CTRL_RST;
                avail_q[c] <= '0;
            end
            data_r_q <= '0;
            err_q    <= 1'b0;
`ifdef CTRL_REGS_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            ctrl_q <= ctrl_d;
            for (int c = 0; c < NUM_CH; c++) begin
                avail_q[c] <= slv_avail[c*AVAIL_WIDTH +: AVAIL_WIDTH];
            end
            data_r_q <= data_r_d;
            err_q    <= err_d;
`ifdef CTRL_REGS_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slv
        assign slv_en[c]         = ctrl_q[c][0];
        assign slv_prio[c*2 +: 2] = ctrl_q[c][2:1];
        assign slv_len[c*3 +: 3]  = ctrl_q[c][5:3];
    end

    assign bus.cmd_data_r = data_r_q;
    assign bus.cmd_err    = err_q;
endmodule

// File: tb/tb_ctrl_regs_mc.sv
// Self-checking bench for ctrl_regs_mc: directed scenarios plus randomized traffic against a
// register-map model. Build with CTRL_REGS_LOCK_EN defined to exercise the LOCK register.
module tb_ctrl_regs_mc;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int AVW = 8;
`ifdef CTRL_REGS_LOCK_EN
    localparam bit HAS_LOCK = 1'b1;
`else
    localparam bit HAS_LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic [NCH*AVW-1:0] slv_avail;
    logic [NCH-1:0]     slv_en;
    logic [2*NCH-1:0]   slv_prio;
    logic [3*NCH-1:0]   slv_len;

    always #5 clk = ~clk;

    ctrl_regs_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ctrl_regs_mc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .AVAIL_WIDTH(AVW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .slv_avail (slv_avail),
        .slv_en    (slv_en),
        .slv_prio  (slv_prio),
        .slv_len   (slv_len)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register contents as plain integers.
    int          ctrl_m  [NCH];
    int          avail_m [NCH];
    bit          lock_m;
    logic [31:0] dr_m;
    bit          err_m;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            ctrl_m[c]  = 7;
            avail_m[c] = 0;
        end
        lock_m = 1'b0;
        dr_m   = '0;
        err_m  = 1'b0;
    endfunction

    function automatic void model_cmd(input int c, input int addr, input int data);
        int kind;  // 0 unmapped, 1 CTRL, 2 STAT, 3 LOCK
        int ch;
        kind = 0;
        ch   = 0;
        if (addr % 4 == 0) begin
            if (addr < 32 && addr / 4 < NCH) begin
                kind = 1; ch = addr / 4;
            end else if (addr >= 32 && addr < 64 && (addr - 32) / 4 < NCH) begin
                kind = 2; ch = (addr - 32) / 4;
            end else if (addr == 64 && HAS_LOCK) begin
                kind = 3;
            end
        end
        err_m = 1'b0;
        case (c)
            1: begin
                if (kind == 1 && !lock_m) ctrl_m[ch] = data & 63;
                else if (kind == 3) begin
                    if ((data & 255) == 165) lock_m = 1'b1;
                end else err_m = 1'b1;
            end
            2: begin
                case (kind)
                    1:       dr_m = 32'(ctrl_m[ch]);
                    2:       dr_m = 32'(avail_m[ch]);
                    3:       dr_m = 32'(lock_m);
                    default: begin dr_m = '0; err_m = 1'b1; end
                endcase
            end
            3: err_m = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic logic [NCH-1:0] exp_en();
        for (int c = 0; c < NCH; c++) exp_en[c] = ctrl_m[c][0];
    endfunction

    function automatic logic [2*NCH-1:0] exp_prio();
        for (int c = 0; c < NCH; c++) exp_prio[c*2 +: 2] = 2'((ctrl_m[c] >> 1) & 3);
    endfunction

    function automatic logic [3*NCH-1:0] exp_len();
        for (int c = 0; c < NCH; c++) exp_len[c*3 +: 3] = 3'((ctrl_m[c] >> 3) & 7);
    endfunction

    // Drive one command for one clock, advance the model, and leave outputs ready to sample.
    task automatic issue(input logic [1:0] c, input int addr, input int data, input bit rst);
        bus.cmd        = c;
        bus.cmd_addr   = addr[AW-1:0];
        bus.cmd_data_w = data;
        rstn           = !rst;
        if (rst) model_reset();
        else begin
            model_cmd(int'(c), addr, data);
            for (int ch = 0; ch < NCH; ch++) avail_m[ch] = int'(slv_avail[ch*AVW +: AVW]);
        end
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        bus.cmd = 2'b00;
    endtask

    task automatic set_avail(input int ch, input int val);
        slv_avail[ch*AVW +: AVW] = val[AVW-1:0];
    endtask

    task automatic test_reset();
        issue(2'b01, 0, 0, 1'b1);
        issue(2'b00, 0, 0, 1'b1);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.cmd_err); end
        n_tests++; if (bus.cmd_data_r !== 32'h0) begin n_fail++; $display("FAIL reset_data_r: got %0h want 0", bus.cmd_data_r); end
        n_tests++; if (slv_en !== 3'b111) begin n_fail++; $display("FAIL reset_en: got %0b want 111", slv_en); end
        n_tests++; if (slv_prio !== 6'b111111) begin n_fail++; $display("FAIL reset_prio: got %0b want 111111", slv_prio); end
        n_tests++; if (slv_len !== 9'b0) begin n_fail++; $display("FAIL reset_len: got %0b want 0", slv_len); end
        for (int c = 0; c < NCH; c++) begin
            issue(2'b10, 4 * c, 0, 1'b0);
            n_tests++; if (bus.cmd_data_r !== 32'h7) begin n_fail++; $display("FAIL reset_ctrl%0d: got %0h want 7", c, bus.cmd_data_r); end
        end
    endtask

    task automatic test_ctrl_write();
        issue(2'b01, 4, 32'hFFFF_FF2A, 1'b0);
        n_tests++; if (slv_en !== 3'b101) begin n_fail++; $display("FAIL wr_en: got %0b want 101", slv_en); end
        n_tests++; if (slv_prio !== 6'b11_01_11) begin n_fail++; $display("FAIL wr_prio: got %0b want 110111", slv_prio); end
        n_tests++; if (slv_len !== 9'b000_101_000) begin n_fail++; $display("FAIL wr_len: got %0b want 000101000", slv_len); end
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %0b want 0", bus.cmd_err); end
        issue(2'b00, 0, 0, 1'b0);
        issue(2'b10, 4, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h2A) begin n_fail++; $display("FAIL wr_readback: got %0h want 2a", bus.cmd_data_r); end
    endtask

    task automatic test_stat();
        set_avail(2, 8'h3C);
        issue(2'b00, 0, 0, 1'b0);
        issue(2'b00, 0, 0, 1'b0);
        issue(2'b10, 32'h28, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h3C) begin n_fail++; $display("FAIL stat_read: got %0h want 3c", bus.cmd_data_r); end
        issue(2'b01, 32'h28, 32'h55, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL stat_wr_err: got %0b want 1", bus.cmd_err); end
        issue(2'b10, 32'h28, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL stat_err_pulse: got %0b want 0", bus.cmd_err); end
        n_tests++; if (bus.cmd_data_r !== 32'h3C) begin n_fail++; $display("FAIL stat_reread: got %0h want 3c", bus.cmd_data_r); end
    endtask

    task automatic test_errors();
        issue(2'b10, 32'h0C, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %0b want 1", bus.cmd_err); end
        n_tests++; if (bus.cmd_data_r !== 32'h0) begin n_fail++; $display("FAIL unmapped_data: got %0h want 0", bus.cmd_data_r); end
        issue(2'b00, 0, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %0b want 0", bus.cmd_err); end
        issue(2'b10, 0, 0, 1'b0);
        issue(2'b10, 32'h02, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %0b want 1", bus.cmd_err); end
        n_tests++; if (bus.cmd_data_r !== 32'h0) begin n_fail++; $display("FAIL misalign_data: got %0h want 0", bus.cmd_data_r); end
        issue(2'b11, 0, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL rsvd_err: got %0b want 1", bus.cmd_err); end
        issue(2'b01, 32'h2C, 32'h1, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL wr_bad_ch_err: got %0b want 1", bus.cmd_err); end
        n_tests++; if (slv_en !== exp_en()) begin n_fail++; $display("FAIL wr_bad_ch_en: got %0b want %0b", slv_en, exp_en()); end
    endtask

`ifdef CTRL_REGS_LOCK_EN
    task automatic test_lock();
        issue(2'b01, 32'h40, 32'h5A, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL lock_bad_key_err: got %0b want 0", bus.cmd_err); end
        issue(2'b10, 32'h40, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h0) begin n_fail++; $display("FAIL lock_bad_key: got %0h want 0", bus.cmd_data_r); end
        issue(2'b01, 32'h40, 32'hA5, 1'b0);
        issue(2'b01, 0, 32'h0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL locked_wr_err: got %0b want 1", bus.cmd_err); end
        n_tests++; if (slv_en[0] !== 1'b1) begin n_fail++; $display("FAIL locked_en0: got %0b want 1", slv_en[0]); end
        issue(2'b10, 32'h40, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h1) begin n_fail++; $display("FAIL lock_read: got %0h want 1", bus.cmd_data_r); end
        issue(2'b00, 0, 0, 1'b1);
        issue(2'b10, 32'h40, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h0) begin n_fail++; $display("FAIL lock_after_rst: got %0h want 0", bus.cmd_data_r); end
        issue(2'b01, 0, 32'h0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL unlocked_wr_err: got %0b want 0", bus.cmd_err); end
        n_tests++; if (slv_en[0] !== 1'b0) begin n_fail++; $display("FAIL unlocked_en0: got %0b want 0", slv_en[0]); end
    endtask
`else
    task automatic test_lock();
        issue(2'b10, 32'h40, 0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL nolock_rd_err: got %0b want 1", bus.cmd_err); end
        issue(2'b01, 32'h40, 32'hA5, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL nolock_wr_err: got %0b want 1", bus.cmd_err); end
        issue(2'b01, 0, 32'h0, 1'b0);
        n_tests++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL nolock_ctrl_err: got %0b want 0", bus.cmd_err); end
        n_tests++; if (slv_en[0] !== 1'b0) begin n_fail++; $display("FAIL nolock_en0: got %0b want 0", slv_en[0]); end
    endtask
`endif

    task automatic test_reset_during_write();
        issue(2'b01, 0, 32'h0, 1'b1);
        issue(2'b10, 0, 0, 1'b0);
        n_tests++; if (bus.cmd_data_r !== 32'h7) begin n_fail++; $display("FAIL rst_wr_lost: got %0h want 7", bus.cmd_data_r); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < NCH; c++) begin
            int v;
            v = int'($urandom_range(0, 63));
            issue(2'b01, 4 * c, v, 1'b0);
            issue(2'b10, 4 * c, 0, 1'b0);
            n_tests++; if (bus.cmd_data_r !== 32'(v)) begin n_fail++; $display("FAIL b2b_ctrl%0d: got %0h want %0h", c, bus.cmd_data_r, v); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r, addr;
            logic [1:0] c;
            slv_avail = NCH*AVW'($urandom);
            r = int'($urandom_range(0, 9));
            c = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r = int'($urandom_range(0, 9));
            if (r < 4)      addr = 4 * int'($urandom_range(0, 7));
            else if (r < 7) addr = 32 + 4 * int'($urandom_range(0, 7));
            else if (r < 8) addr = 64;
            else            addr = int'($urandom_range(0, 255));
            issue(c, addr, int'($urandom), ($urandom_range(0, 99) == 0));
            n_tests++; if (bus.cmd_data_r !== dr_m) begin n_fail++; $display("FAIL rnd%0d_data_r: got %0h want %0h", i, bus.cmd_data_r, dr_m); end
            n_tests++; if (bus.cmd_err !== err_m) begin n_fail++; $display("FAIL rnd%0d_err: got %0b want %0b", i, bus.cmd_err, err_m); end
            n_tests++; if ({slv_len, slv_prio, slv_en} !== {exp_len(), exp_prio(), exp_en()}) begin
                n_fail++; $display("FAIL rnd%0d_slv: got %0h want %0h", i, {slv_len, slv_prio, slv_en}, {exp_len(), exp_prio(), exp_en()});
            end
        end
    endtask

    initial begin
        rstn           = 1'b0;
        bus.cmd        = 2'b00;
        bus.cmd_addr   = '0;
        bus.cmd_data_w = '0;
        slv_avail      = '0;
        model_reset();
        test_reset();
        test_ctrl_write();
        test_stat();
        test_errors();
        test_lock();
        test_reset_during_write();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
